clock_generator: RTL and testbench
==================================

Name: clock_generator

Overview:
Parametrised successor to the core clock divider. Produces the CPU clock from clock_100mhz in four modes: fast divide, slow divide, single-step and halt. Divisor and mode changes are glitch-free: they are applied only at falling-edge boundaries of the generated clock. Also provides a one-cycle enable pulse and a rising-edge counter for the debug/display path.

Parameters:
DIV_WIDTH, 5, width of clock_divisor
SLOW_SHIFT, 18, slow-mode scale exponent; must be >= 1
CNT_WIDTH, DIV_WIDTH+SLOW_SHIFT+1, half-period counter width

Ports:
clock_100mhz  in  1  reference clock
reset  in  1  asynchronous, active-high
clock_divisor  in  DIV_WIDTH  requested divisor d
mode  in  2  requested mode: 00 fast, 01 slow, 10 step, 11 halt
step_request  in  1  synchronous level; each rising edge requests one step
clock_divided  out  1  generated clock (registered)
clock_enable  out  1  one-cycle pulse on each rise of clock_divided
mode_applied  out  2  mode currently in effect
step_busy  out  1  a step is in flight or pending
rise_count  out  32  rising edges of clock_divided, wraps at 2^32

Behaviour:
- Reset values: clock_divided=0, clock_enable=0, mode_applied=11 (halt), step_busy=0, rise_count=0, counter=0, no pending step. The registered step_request previous-value register resets to 0.
- Half period H, in clock_100mhz cycles, is computed from the applied divisor da:
  - fast and step: H = da + 2
  - slow: H = da*2^SLOW_SHIFT + 2^(SLOW_SHIFT-1) + 1
- All arithmetic is unsigned and computed at CNT_WIDTH with no overflow.
- Counter: increments every cycle while running. On the cycle the counter equals H-1, clock_divided toggles and the counter clears. Each phase therefore lasts exactly H cycles, giving 50% duty.
- Update point: the cycle in which clock_divided toggles 1->0, or any cycle while idle. Idle means halt, or step mode with no step in flight.
  - At an update point, mode and clock_divisor are sampled into mode_applied/da and the counter clears.
  - The new settings govern the following low phase.
  - Inputs sampled at any other time have no effect. A change during a high phase takes effect only after that phase completes at the old H.
- Leaving idle into fast/slow: clock_divided stays low for H cycles counted from the update cycle, then rises.
- Halt: clock_divided held 0, counter held 0, rise_count frozen.
- Step:
  - Rising edge of step_request = registered previous 0, current 1.
  - An edge while idle in step mode starts a step: clock_divided rises on the next edge, stays high H cycles, then low H cycles, then returns to idle.
  - An edge during a step sets a single pending flag; further edges are ignored while the flag is set.
  - When a step ends with the pending flag set and the mode is still step, the next step starts immediately and the flag clears.
  - If the update point at the step's falling toggle selects a non-step mode, the pending flag clears and the new mode runs.
  - step_busy = step in flight OR pending.
- clock_enable: 1 exactly in the cycle in which clock_divided first reads 1. It is registered alongside clock_divided and is 0 otherwise.
- rise_count: increments by 1 in the same cycle clock_enable is 1; 0xFFFFFFFF wraps to 0.
- Reset asserted mid-phase: all state returns to reset values immediately. After deassertion the block is idle (halt), so the first clock samples the inputs.
- Simultaneous terminal count and step edge: toggle has priority; the edge is recorded as pending.

Test Plan:
- Reset release with mode=00, d=0: clock_divided low 2 cycles, then period 4 (2 high/2 low); clock_enable pulses once per period; rise_count=5 after 5 rises.
- SLOW_SHIFT=4, mode=01, d=3: H=3*16+8+1=57; high and low phases exactly 57 cycles each.
- Fast, d=2 (H=4); change d to 9 mid-high-phase: current high phase stays 4 cycles; the following low phase and all later phases are 11 cycles; no pulse shorter than 4 cycles.
- Mode=10, d=1: one step_request edge gives one 3-cycle high/3-cycle low pulse, rise_count +1. Two edges within one step give exactly 2 pulses, back-to-back. A third edge while pending is ignored.
- Fast running, switch to 11: output completes the current high phase, then holds 0; mode_applied=11 after that falling edge; rise_count frozen.
- Assert reset mid-high-phase in slow mode: clock_divided=0 and rise_count=0 immediately (asynchronous); mode_applied=11.

Source files
------------

// File: rtl/clock_generator.sv
// clock_generator: produces the CPU clock from clock_100mhz in fast, slow,
// single-step and halt modes. Mode/divisor changes are taken only at the
// falling edge of the generated clock (or while idle), so no short pulses
// are ever produced. Also provides a rise pulse and a 32-bit rise counter.
module clock_generator #(
    parameter int DIV_WIDTH  = 5,
    parameter int SLOW_SHIFT = 18,
    parameter int CNT_WIDTH  = DIV_WIDTH + SLOW_SHIFT + 1
) (
    input  logic                 clock_100mhz,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] clock_divisor,
    input  logic [1:0]           mode,
    input  logic                 step_request,
    output logic                 clock_divided,
    output logic                 clock_enable,
    output logic [1:0]           mode_applied,
    output logic                 step_busy,
    output logic [31:0]          rise_count
);

    typedef enum logic [1:0] {
        MODE_FAST = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HALT = 2'b11
    } mode_t;

    // Constant part of the slow half period: 2^(SLOW_SHIFT-1) + 1
    localparam logic [CNT_WIDTH-1:0] SLOW_BIAS =
        (CNT_WIDTH'(1) << (SLOW_SHIFT - 1)) + CNT_WIDTH'(1);

    // Registered state
    mode_t                r_mode;
    logic [DIV_WIDTH-1:0] r_da;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_clk;
    logic                 r_en;
    logic                 r_step_act;
    logic                 r_pend;
    logic                 r_req_prev;
    logic [31:0]          r_rise;

    // Next-state values
    mode_t                w_mode_nxt;
    logic [DIV_WIDTH-1:0] w_da_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_clk_nxt;
    logic                 w_en_nxt;
    logic                 w_step_act_nxt;
    logic                 w_pend_nxt;
    logic [31:0]          w_rise_nxt;

    // Decode helpers
    mode_t                w_mode_in;
    logic [CNT_WIDTH-1:0] w_da_ext;
    logic [CNT_WIDTH-1:0] w_half;
    logic                 w_tc;
    logic                 w_idle;
    logic                 w_edge;

    assign w_mode_in = mode_t'(mode);
    assign w_da_ext  = CNT_WIDTH'(r_da);
    assign w_half    = (r_mode == MODE_SLOW) ? (w_da_ext << SLOW_SHIFT) + SLOW_BIAS
                                             : w_da_ext + CNT_WIDTH'(2);
    assign w_tc      = (r_cnt == w_half - CNT_WIDTH'(1));
    assign w_idle    = (r_mode == MODE_HALT) || ((r_mode == MODE_STEP) && !r_step_act);
    assign w_edge    = step_request && !r_req_prev;

    // Next-state logic: idle sampling, phase toggles and step sequencing
    always_comb begin
        w_mode_nxt     = r_mode;
        w_da_nxt       = r_da;
        w_cnt_nxt      = r_cnt + CNT_WIDTH'(1);
        w_clk_nxt      = r_clk;
        w_en_nxt       = 1'b0;
        w_step_act_nxt = r_step_act;
        w_pend_nxt     = r_pend;
        w_rise_nxt     = r_rise;

        if (w_idle) begin
            // Idle: every cycle is an update point; output held low
            w_mode_nxt     = w_mode_in;
            w_da_nxt       = clock_divisor;
            w_cnt_nxt      = '0;
            w_clk_nxt      = 1'b0;
            w_step_act_nxt = 1'b0;
            w_pend_nxt     = 1'b0;
            if ((w_mode_in == MODE_STEP) && w_edge) begin
                w_clk_nxt      = 1'b1;
                w_en_nxt       = 1'b1;
                w_rise_nxt     = r_rise + 32'd1;
                w_step_act_nxt = 1'b1;
            end
        end else if (w_tc) begin
            w_cnt_nxt = '0;
            if (r_clk) begin
                // Falling toggle: the only running update point
                w_clk_nxt  = 1'b0;
                w_mode_nxt = w_mode_in;
                w_da_nxt   = clock_divisor;
                if ((r_mode == MODE_STEP) && w_edge)
                    w_pend_nxt = 1'b1;
                // A step keeps running its low phase only if step stays selected
                w_step_act_nxt = (r_mode == MODE_STEP) && (w_mode_in == MODE_STEP);
                if (w_mode_in != MODE_STEP)
                    w_pend_nxt = 1'b0;
            end else if (r_mode == MODE_STEP) begin
                // End of a step's low phase: chain a pending step or go idle.
                // An edge landing on this cycle counts as pending.
                if (r_pend || w_edge) begin
                    w_clk_nxt  = 1'b1;
                    w_en_nxt   = 1'b1;
                    w_rise_nxt = r_rise + 32'd1;
                    w_pend_nxt = 1'b0;
                end else begin
                    w_step_act_nxt = 1'b0;
                end
            end else begin
                w_clk_nxt  = 1'b1;
                w_en_nxt   = 1'b1;
                w_rise_nxt = r_rise + 32'd1;
            end
        end else if ((r_mode == MODE_STEP) && w_edge) begin
            // Mid-step edge: remember at most one further step
            w_pend_nxt = 1'b1;
        end
    end

    // State register with asynchronous active-high reset
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            r_mode     <= MODE_HALT;
            r_da       <= '0;
            r_cnt      <= '0;
            r_clk      <= 1'b0;
            r_en       <= 1'b0;
            r_step_act <= 1'b0;
            r_pend     <= 1'b0;
            r_req_prev <= 1'b0;
            r_rise     <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_da       <= w_da_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clk      <= w_clk_nxt;
            r_en       <= w_en_nxt;
            r_step_act <= w_step_act_nxt;
            r_pend     <= w_pend_nxt;
            r_req_prev <= step_request;
            r_rise     <= w_rise_nxt;
        end
    end

    assign clock_divided = r_clk;
    assign clock_enable  = r_en;
    assign mode_applied  = r_mode;
    assign step_busy     = r_step_act || r_pend;
    assign rise_count    = r_rise;

endmodule

// File: tb/tb_clock_generator.sv
// Bench for clock_generator: phase-countdown reference model checked every
// cycle, plus directed scenarios with literal expected phase lengths.
module tb_clock_generator;

    localparam int DW = 5;
    localparam int SS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] div = '0;
    logic [1:0]    mode = 2'b00;
    logic          req = 1'b0;
    logic          clock_divided, clock_enable, step_busy;
    logic [1:0]    mode_applied;
    logic [31:0]   rise_count;

    int n_checks = 0;
    int n_errors = 0;

    clock_generator #(.DIV_WIDTH(DW), .SLOW_SHIFT(SS)) dut (
        .clock_100mhz (clk),
        .reset        (reset),
        .clock_divisor(div),
        .mode         (mode),
        .step_request (req),
        .clock_divided(clock_divided),
        .clock_enable (clock_enable),
        .mode_applied (mode_applied),
        .step_busy    (step_busy),
        .rise_count   (rise_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_clk, m_en, m_step, m_pend, m_prev, m_edge, m_idle;
    logic [1:0]  m_mode;
    int          m_da;
    longint      m_left;
    logic [31:0] m_rise;

    function automatic longint hlen(input logic [1:0] md, input int da);
        if (md == 2'b01) return longint'(da) * (longint'(1) << SS) + (longint'(1) << (SS - 1)) + 1;
        return longint'(da) + 2;
    endfunction

    task automatic m_reset();
        m_clk = 0; m_en = 0; m_step = 0; m_pend = 0; m_prev = 0;
        m_mode = 2'b11; m_da = 0; m_left = 0; m_rise = 0;
    endtask

    task automatic m_start();
        m_clk = 1; m_en = 1; m_step = 1; m_rise = m_rise + 1;
        m_left = hlen(m_mode, m_da);
    endtask

    task automatic m_tick();
        m_edge = req && !m_prev;
        m_prev = req;
        m_en = 0;
        m_idle = (m_mode == 2'b11) || (m_mode == 2'b10 && !m_step);
        if (m_idle) begin
            m_mode = mode; m_da = int'(div); m_clk = 0; m_pend = 0; m_step = 0;
            m_left = hlen(m_mode, m_da);
            if (mode == 2'b10 && m_edge) m_start();
        end else begin
            m_left = m_left - 1;
            if (m_left != 0) begin
                if (m_mode == 2'b10 && m_edge) m_pend = 1;
            end else if (m_clk) begin
                m_clk = 0;
                if (m_mode == 2'b10 && m_edge) m_pend = 1;
                m_step = (m_mode == 2'b10) && (mode == 2'b10);
                if (mode != 2'b10) m_pend = 0;
                m_mode = mode; m_da = int'(div);
                m_left = hlen(m_mode, m_da);
            end else if (m_mode == 2'b10) begin
                if (m_pend || m_edge) begin m_pend = 0; m_start(); end
                else m_step = 0;
            end else begin
                m_clk = 1; m_en = 1; m_rise = m_rise + 1;
                m_left = hlen(m_mode, m_da);
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_tick();
        end
    end

    // ---------------- per-cycle compare + phase-length tracking ----------------
    int   hi_q[$];
    int   lo_q[$];
    logic run_val = 1'b0;
    int   run_len = 0;
    bit   run_ok  = 0;
    int   cyc     = 0;

    task automatic clear_phases();
        hi_q.delete(); lo_q.delete(); run_ok = 0; run_len = 0; run_val = clock_divided;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                n_checks++;
                if ({clock_divided, clock_enable, mode_applied, step_busy, rise_count} !==
                    {m_clk, m_en, m_mode, (m_step | m_pend), m_rise}) begin
                    n_errors++;
                    $display("FAIL model_cmp cyc=%0d got clk=%b en=%b mode=%b busy=%b rise=%0d expected clk=%b en=%b mode=%b busy=%b rise=%0d",
                             cyc, clock_divided, clock_enable, mode_applied, step_busy, rise_count,
                             m_clk, m_en, m_mode, (m_step | m_pend), m_rise);
                end
                if (clock_divided === run_val) run_len++;
                else begin
                    if (run_ok) begin
                        if (run_val) hi_q.push_back(run_len);
                        else lo_q.push_back(run_len);
                    end
                    run_ok = 1; run_val = clock_divided; run_len = 1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_clk(input logic v, input int maxc, input string nm);
        int n = 0;
        while (clock_divided !== v && n < maxc) begin tick(1); n++; end
        check(nm, {31'd0, clock_divided}, {31'd0, v});
    endtask

    task automatic wait_en(input int maxc, input string nm);
        int n = 0;
        while (clock_enable !== 1'b1 && n < maxc) begin tick(1); n++; end
        check(nm, {31'd0, clock_enable}, 32'd1);
    endtask

    task automatic check_all(input string nm, input int q[$], input int first_exp, input int rest_exp, input int min_sz);
        check({nm, "_count_ok"}, (q.size() >= min_sz) ? 32'd1 : 32'd0, 32'd1);
        foreach (q[i]) check(nm, q[i], (i == 0) ? first_exp : rest_exp);
    endtask

    logic [31:0] r0;

    // ---------------- directed scenarios ----------------
    initial begin
        #2 reset = 1'b1;
        #1;
        check("rst_clk",  {31'd0, clock_divided}, 32'd0);
        check("rst_en",   {31'd0, clock_enable}, 32'd0);
        check("rst_mode", {30'd0, mode_applied}, 32'd3);
        check("rst_busy", {31'd0, step_busy}, 32'd0);
        check("rst_rise", rise_count, 32'd0);

        // Fast, d=0: low 2 cycles after release, then period 4
        mode = 2'b00; div = 5'd0;
        tick(2);
        reset = 1'b0;
        clear_phases();
        tick(1); check("t1_low0", {31'd0, clock_divided}, 32'd0);
        tick(1); check("t1_low1", {31'd0, clock_divided}, 32'd0);
        tick(1); check("t1_rise", {31'd0, clock_divided}, 32'd1);
        check("t1_en", {31'd0, clock_enable}, 32'd1);
        check("t1_cnt1", rise_count, 32'd1);
        tick(16);
        check("t1_cnt5", rise_count, 32'd5);
        check("t1_en5", {31'd0, clock_enable}, 32'd1);
        check_all("t1_hi", hi_q, 2, 2, 4);
        check_all("t1_lo", lo_q, 2, 2, 3);

        // Slow, d=3, SLOW_SHIFT=4: H = 57
        mode = 2'b01; div = 5'd3;
        tick(10);
        check("t2_mode", {30'd0, mode_applied}, 32'd1);
        clear_phases();
        tick(300);
        check_all("t2_hi", hi_q, 57, 57, 2);
        check_all("t2_lo", lo_q, 57, 57, 2);

        // Fast d=2 (H=4), change to d=9 mid-high phase
        mode = 2'b00; div = 5'd2;
        tick(130);
        check("t3_mode", {30'd0, mode_applied}, 32'd0);
        wait_clk(1'b0, 20, "t3_wait_low");
        clear_phases();
        wait_en(20, "t3_wait_rise");
        tick(1);
        div = 5'd9;
        tick(60);
        check_all("t3_hi", hi_q, 4, 11, 2);
        check_all("t3_lo", lo_q, 11, 11, 2);

        // Step mode, d=1 (H=3): single step
        mode = 2'b10; div = 5'd1;
        tick(30);
        check("t4_mode", {30'd0, mode_applied}, 32'd2);
        check("t4_idle_clk", {31'd0, clock_divided}, 32'd0);
        check("t4_idle_busy", {31'd0, step_busy}, 32'd0);
        r0 = rise_count;
        clear_phases();
        req = 1'b1;
        tick(1);
        check("t4_step_clk", {31'd0, clock_divided}, 32'd1);
        check("t4_step_en", {31'd0, clock_enable}, 32'd1);
        check("t4_step_busy", {31'd0, step_busy}, 32'd1);
        req = 1'b0;
        tick(10);
        check("t4_single_rise", rise_count, r0 + 32'd1);
        check("t4_single_busy", {31'd0, step_busy}, 32'd0);
        check("t4_single_nhi", hi_q.size(), 32'd1);
        check_all("t4_single_hi", hi_q, 3, 3, 1);

        // Two edges in one step plus a third while pending
        r0 = rise_count;
        clear_phases();
        for (int k = 0; k < 6; k++) begin
            req = (k % 2 == 0);
            tick(1);
        end
        check("t4_pend_busy", {31'd0, step_busy}, 32'd1);
        tick(20);
        check("t4_double_rise", rise_count, r0 + 32'd2);
        check("t4_double_nhi", hi_q.size(), 32'd2);
        check_all("t4_double_hi", hi_q, 3, 3, 2);
        check_all("t4_double_lo", lo_q, 3, 3, 1);
        check("t4_double_busy", {31'd0, step_busy}, 32'd0);

        // Fast d=2 then halt mid-high phase
        mode = 2'b00; div = 5'd2;
        tick(20);
        wait_clk(1'b0, 20, "t5_wait_low");
        clear_phases();
        wait_en(20, "t5_wait_rise");
        r0 = rise_count;
        mode = 2'b11;
        tick(1);
        check("t5_still_fast", {30'd0, mode_applied}, 32'd0);
        check("t5_still_high", {31'd0, clock_divided}, 32'd1);
        tick(20);
        check("t5_halt_mode", {30'd0, mode_applied}, 32'd3);
        check("t5_halt_clk", {31'd0, clock_divided}, 32'd0);
        check("t5_halt_rise", rise_count, r0);
        check("t5_nhi", hi_q.size(), 32'd1);
        check_all("t5_hi", hi_q, 4, 4, 1);

        // Slow d=0 (H=9), asynchronous reset mid-high phase
        mode = 2'b01; div = 5'd0;
        tick(5);
        wait_en(40, "t6_wait_rise");
        tick(2);
        check("t6_high", {31'd0, clock_divided}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_clk", {31'd0, clock_divided}, 32'd0);
        check("t6_rst_rise", rise_count, 32'd0);
        check("t6_rst_mode", {30'd0, mode_applied}, 32'd3);
        check("t6_rst_busy", {31'd0, step_busy}, 32'd0);
        tick(3);
        reset = 1'b0;
        tick(1);
        check("t6_post_mode", {30'd0, mode_applied}, 32'd1);
        check("t6_post_clk", {31'd0, clock_divided}, 32'd0);
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
